// File: rtl/i2c_mon_fmt_pkg.sv
// Shared constants and the hex-digit helper for the I2C monitor ASCII formatter.
package i2c_mon_fmt_pkg;

   localparam logic [1:0] EV_START     = 2'd0;
   localparam logic [1:0] EV_STOP      = 2'd1;
   localparam logic [1:0] EV_DATA_ACK  = 2'd2;
   localparam logic [1:0] EV_DATA_NACK = 2'd3;

   localparam logic [7:0] CH_S     = 8'h53;
   localparam logic [7:0] CH_P     = 8'h50;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_CR    = 8'h0D;
   localparam logic [7:0] CH_LF    = 8'h0A;
   localparam logic [7:0] CH_PLUS  = 8'h2B;
   localparam logic [7:0] CH_MINUS = 8'h2D;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_S_CH = 4'd1,
      ST_SP   = 4'd2,
      ST_WCR  = 4'd3,
      ST_WLF  = 4'd4,
      ST_HI   = 4'd5,
      ST_LO   = 4'd6,
      ST_MARK = 4'd7,
      ST_P_CH = 4'd8,
      ST_CR   = 4'd9,
      ST_LF   = 4'd10
   } state_e;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      logic [7:0] wide;
      wide = {4'd0, nib};
      if (nib < 4'd10) begin
         hex_ascii = 8'h30 + wide;
      end else begin
         hex_ascii = 8'h41 + (wide - 8'd10);
      end
   endfunction

endpackage

// File: rtl/i2c_mon_ascii_fmt.sv
// Formats I2C monitor events as ASCII text, one character per cycle, into the UART tx FIFO.
// Backpressure reaches the event source only through ev_ready.
module i2c_mon_ascii_fmt
   import i2c_mon_fmt_pkg::*;
#(
   parameter int unsigned LINE_MAX = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ev_valid,
   output logic       ev_ready,
   input  logic [1:0] ev_type,
   input  logic [7:0] ev_data,
   input  logic       tx_fifo_full,
   output logic       tx_fifo_we,
   output logic [7:0] tx_fifo_wr_data,
   output logic       busy
);

   localparam logic [7:0] LINE_MAX_C = LINE_MAX[7:0];

   state_e     state_q, state_d, nxt_s;
   logic [7:0] line_cnt_q, line_cnt_d;
   logic [1:0] type_q, type_d;
   logic [7:0] byte_q, byte_d;
   logic       emit_s;
   logic [7:0] char_s;
   logic       is_data_s;

   assign is_data_s       = (type_q == EV_DATA_ACK) || (type_q == EV_DATA_NACK);
   assign ev_ready        = (state_q == ST_IDLE);
   assign busy            = (state_q != ST_IDLE);
   assign tx_fifo_we      = emit_s && !tx_fifo_full;
   assign tx_fifo_wr_data = char_s;

   // Character decode and successor state for every emit state.
   always_comb begin
      emit_s = 1'b1;
      char_s = 8'h00;
      nxt_s  = ST_IDLE;
      case (state_q)
         ST_IDLE: begin
            emit_s = 1'b0;
            if (ev_type == EV_START) begin
               nxt_s = ST_S_CH;
            end else if (ev_type == EV_STOP) begin
               nxt_s = ST_P_CH;
            end else if (line_cnt_q == LINE_MAX_C) begin
               nxt_s = ST_WCR;
            end else begin
               nxt_s = ST_HI;
            end
         end
         ST_S_CH: begin char_s = CH_S;                 nxt_s = ST_SP;   end
         ST_SP:   begin char_s = CH_SP;                nxt_s = ST_IDLE; end
         ST_WCR:  begin char_s = CH_CR;                nxt_s = ST_WLF;  end
         ST_WLF:  begin char_s = CH_LF;                nxt_s = ST_HI;   end
         ST_HI:   begin char_s = hex_ascii(byte_q[7:4]); nxt_s = ST_LO; end
         ST_LO:   begin char_s = hex_ascii(byte_q[3:0]); nxt_s = ST_MARK; end
         ST_MARK: begin
            char_s = (type_q == EV_DATA_NACK) ? CH_MINUS : CH_PLUS;
            nxt_s  = ST_SP;
         end
         ST_P_CH: begin char_s = CH_P;                 nxt_s = ST_CR;   end
         ST_CR:   begin char_s = CH_CR;                nxt_s = ST_LF;   end
         ST_LF:   begin char_s = CH_LF;                nxt_s = ST_IDLE; end
         default: begin emit_s = 1'b0;                 nxt_s = ST_IDLE; end
      endcase
   end

   // Next-state, held-event and line-counter updates; emit states move only on a write.
   always_comb begin
      state_d    = state_q;
      line_cnt_d = line_cnt_q;
      type_d     = type_q;
      byte_d     = byte_q;
      if (state_q == ST_IDLE) begin
         if (ev_valid) begin
            state_d = nxt_s;
            type_d  = ev_type;
            byte_d  = ev_data;
         end else begin
            state_d = ST_IDLE;
         end
      end else if (tx_fifo_we || !emit_s) begin
         state_d = nxt_s;
      end else begin
         state_d = state_q;
      end

      if (tx_fifo_we && ((state_q == ST_WLF) || (state_q == ST_LF))) begin
         line_cnt_d = 8'd0;
      end else if (tx_fifo_we && (state_q == ST_SP) && is_data_s) begin
         line_cnt_d = line_cnt_q + 8'd1;
      end else begin
         line_cnt_d = line_cnt_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         line_cnt_q <= 8'd0;
         type_q     <= 2'd0;
         byte_q     <= 8'd0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         type_q     <= type_d;
         byte_q     <= byte_d;
      end
   end

endmodule

// File: tb/tb_i2c_mon_ascii_fmt.sv
// Scoreboard bench for i2c_mon_ascii_fmt: directed hand-computed strings, then a modelled random stream.
module tb_i2c_mon_ascii_fmt;

   localparam int LM = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ev_valid = 1'b0;
   logic       ev_ready;
   logic [1:0] ev_type = 2'd0;
   logic [7:0] ev_data = 8'd0;
   logic       tx_fifo_full = 1'b0;
   logic       tx_fifo_we;
   logic [7:0] tx_fifo_wr_data;
   logic       busy;

   logic [7:0] exp_q[$];
   int total = 0;
   int bad = 0;
   int offered = 0;
   int accepted = 0;
   int mlc = 0;
   bit rand_en = 1'b0;

   i2c_mon_ascii_fmt #(.LINE_MAX(LM)) dut (
      .clk(clk), .reset(reset),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_type(ev_type), .ev_data(ev_data),
      .tx_fifo_full(tx_fifo_full), .tx_fifo_we(tx_fifo_we),
      .tx_fifo_wr_data(tx_fifo_wr_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every FIFO write is popped against the scoreboard.
   always @(negedge clk) begin
      logic [7:0] e;
      if (ev_valid && ev_ready) accepted++;
      if (tx_fifo_we === 1'b1) begin
         total++;
         if (tx_fifo_full) begin
            bad++;
            $display("FAIL we_while_full: we=1 with full=1 at %0t", $time);
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL char_extra: got %02h expected nothing at %0t", tx_fifo_wr_data, $time);
         end else begin
            e = exp_q.pop_front();
            if (tx_fifo_wr_data !== e) begin
               bad++;
               $display("FAIL char: got %02h expected %02h at %0t", tx_fifo_wr_data, e, $time);
            end
         end
      end
   end

   // Random backpressure source for the stream test.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (rand_en) tx_fifo_full = ($urandom_range(0, 2) == 0);
      end
   end

   task automatic push_n(input int n, input logic [127:0] v);
      for (int i = 0; i < n; i++) exp_q.push_back(v[8*(n-1-i) +: 8]);
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      return (n < 4'd10) ? (8'd48 + {4'd0, n}) : (8'd55 + {4'd0, n});
   endfunction

   task automatic model_ev(input logic [1:0] t, input logic [7:0] d);
      if (t == 2'd0) begin
         push_n(2, 16'h5320);
      end else if (t == 2'd1) begin
         push_n(3, 24'h500D0A);
         mlc = 0;
      end else begin
         if (mlc == LM) begin
            push_n(2, 16'h0D0A);
            mlc = 0;
         end
         exp_q.push_back(hexc(d[7:4]));
         exp_q.push_back(hexc(d[3:0]));
         exp_q.push_back((t == 2'd3) ? 8'h2D : 8'h2B);
         exp_q.push_back(8'h20);
         mlc = (mlc + 1) % 256;
      end
   endtask

   // Offer one event; returns #1 after the accepting edge. exp_lat>=0 checks busy-cycle count.
   task automatic send(input logic [1:0] t, input logic [7:0] d, input int exp_lat);
      int n;
      bit to;
      ev_type = t;
      ev_data = d;
      ev_valid = 1'b1;
      offered++;
      n = 0;
      to = 1'b0;
      while (!ev_ready && !to) begin
         @(posedge clk); #1;
         n++;
         if (n > 500) to = 1'b1;
      end
      check("accept_timeout", {31'd0, to}, 32'd0);
      if (!to) begin
         @(posedge clk); #1;
      end
      ev_valid = 1'b0;
      if (exp_lat >= 0 && !to) begin
         n = 0;
         while (!ev_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
         end
         check("ready_low_cycles", n, exp_lat);
      end
   endtask

   initial begin
      int n;
      logic [1:0] t;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_ev_ready", {31'd0, ev_ready}, 32'd1);
      check("rst_we", {31'd0, tx_fifo_we}, 32'd0);
      check("rst_data", {24'd0, tx_fifo_wr_data}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;

      // Basic sequence: "S A5+ 3C- P\r\n"
      push_n(13, 104'h53_20_41_35_2B_20_33_43_2D_20_50_0D_0A);
      send(2'd0, 8'h00, 2);
      send(2'd2, 8'hA5, 4);
      send(2'd3, 8'h3C, 4);
      send(2'd1, 8'h00, 3);

      // Digit boundaries: "00+ FF+ P\r\n9A+ P\r\n"
      push_n(11, 88'h30_30_2B_20_46_46_2B_20_50_0D_0A);
      push_n(7, 56'h39_41_2B_20_50_0D_0A);
      send(2'd2, 8'h00, 4);
      send(2'd2, 8'hFF, 4);
      send(2'd1, 8'h00, 3);
      send(2'd2, 8'h9A, 4);
      send(2'd1, 8'h00, 3);

      // Line wrap at LINE_MAX=2: "11+ 11+ \r\n11+ P\r\n11+ P\r\n"
      push_n(14, 112'h31_31_2B_20_31_31_2B_20_0D_0A_31_31_2B_20);
      push_n(10, 80'h50_0D_0A_31_31_2B_20_50_0D_0A);
      send(2'd2, 8'h11, 4);
      send(2'd2, 8'h11, 4);
      send(2'd2, 8'h11, 6);
      send(2'd1, 8'h00, 3);
      send(2'd2, 8'h11, 4);
      send(2'd1, 8'h00, 3);

      // Backpressure held in LO of 0x7E
      push_n(7, 56'h37_45_2B_20_50_0D_0A);
      send(2'd2, 8'h7E, -1);
      @(posedge clk); #1;
      tx_fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_we", {31'd0, tx_fifo_we}, 32'd0);
         check("hold_data", {24'd0, tx_fifo_wr_data}, 32'h45);
         @(posedge clk); #1;
      end
      tx_fifo_full = 1'b0;
      send(2'd1, 8'h00, 3);

      // Reset during HI aborts the event with no characters written
      send(2'd2, 8'h5A, -1);
      reset = 1'b1;
      tx_fifo_full = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tx_fifo_full = 1'b0;
      mlc = 0;
      check("abort_we", {31'd0, tx_fifo_we}, 32'd0);
      check("abort_ready", {31'd0, ev_ready}, 32'd1);
      check("abort_busy", {31'd0, busy}, 32'd0);
      push_n(2, 16'h5320);
      send(2'd0, 8'h00, 2);

      // Random stream against the reference model with random backpressure
      rand_en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         t = 2'($urandom_range(0, 3));
         ev_data = 8'($urandom_range(0, 255));
         model_ev(t, ev_data);
         send(t, ev_data, -1);
      end
      rand_en = 1'b0;
      tx_fifo_full = 1'b0;

      n = 0;
      while ((exp_q.size() != 0 || busy) && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain_queue", exp_q.size(), 32'd0);
      check("offered_vs_accepted", accepted, offered);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
